// File: rtl/des_pkg.sv
// Shared DES definitions: controller states, FIPS 46-3 permutation/S-box tables and helpers.
// Vectors are MSB-first: bit [N-1] of an N-bit vector is FIPS bit 1.
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KEYSET,
        ST_ROUND,
        ST_DONE
    } state_e;

    localparam int ROUNDS = 16;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };

    // S1..S8 back to back, 64 entries each, indexed by row*16 + column.
    localparam int SBOX_T [512] = '{
        14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
        15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
        10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
         7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
         2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
        12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
         4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
        13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11
    };

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
        return y;
    endfunction

    // Outer bits b1,b6 select the row, inner bits b2..b5 the column.
    function automatic logic [3:0] sbox(input int box, input logic [5:0] b);
        int idx;
        idx = box * 64 + int'({b[5], b[0]}) * 16 + int'(b[4:1]);
        return SBOX_T[idx][3:0];
    endfunction

    // Subkey r (1..16) occupies [subkey_lsb(r) +: 48] of the 768-bit bus.
    function automatic int subkey_lsb(input int r);
        return 48 * (r - 1);
    endfunction

endpackage

// File: rtl/des_f_func.sv
// Combinational DES round function f(R,K) = P(S(E(R) ^ K)).
module des_f_func
    import des_pkg::*;
(
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);

    logic [47:0] mixed;
    logic [31:0] sOut;

    always_comb begin
        mixed = e_expand(r_i) ^ k_i;
        sOut  = '0;
        for (int s = 0; s < 8; s++) begin
            sOut[31-4*s -: 4] = sbox(s, mixed[47-6*s -: 6]);
        end
        f_o = p_perm(sOut);
    end

endmodule

// File: rtl/des_iter_ctrl.sv
// Iterative DES controller: one Feistel round per clock through a single f-function,
// subkeys supplied by an external generator driven from key_out/mode_out.
module des_iter_ctrl
    import des_pkg::*;
#(
    parameter bit SUBKEY_REG = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic [63:0]  in_key,
    input  logic         in_mode,
    output logic [63:0]  key_out,
    output logic         mode_out,
    input  logic [767:0] subkeys_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         busy,
    output logic [3:0]   round_idx
);

    state_e         state_q, state_d;
    logic [31:0]    left_q, left_d, right_q, right_d;
    logic [63:0]    key_q, key_d;
    logic           mode_q, mode_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [767:0]   subkeys_q, subkeys_d;
    logic [767:0]   skBus;
    logic [47:0]    roundKey;
    logic [31:0]    fOut;
    logic           accept;

    assign skBus    = SUBKEY_REG ? subkeys_q : subkeys_in;
    assign roundKey = skBus[subkey_lsb(int'(cnt_q) + 1) +: 48];

    des_f_func u_f (
        .r_i (right_q),
        .k_i (roundKey),
        .f_o (fOut)
    );

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign round_idx = cnt_q;
    assign key_out   = key_q;
    assign mode_out  = mode_q;
    assign out_data  = fp({right_q, left_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            left_q    <= '0;
            right_q   <= '0;
            key_q     <= '0;
            mode_q    <= 1'b0;
            cnt_q     <= '0;
            subkeys_q <= '0;
        end else begin
            state_q   <= state_d;
            left_q    <= left_d;
            right_q   <= right_d;
            key_q     <= key_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            subkeys_q <= subkeys_d;
        end
    end

    // An accept in DONE takes priority over returning to IDLE so blocks run back to back.
    always_comb begin
        state_d   = state_q;
        left_d    = left_q;
        right_d   = right_q;
        key_d     = key_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        subkeys_d = subkeys_q;
        if (accept) begin
            {left_d, right_d} = ip(in_data);
            key_d   = in_key;
            mode_d  = in_mode;
            cnt_d   = '0;
            state_d = SUBKEY_REG ? ST_KEYSET : ST_ROUND;
        end else begin
            case (state_q)
                ST_KEYSET: begin
                    subkeys_d = subkeys_in;
                    state_d   = ST_ROUND;
                end
                ST_ROUND: begin
                    left_d  = right_q;
                    right_d = left_q ^ fOut;
                    if (cnt_q == 4'(ROUNDS - 1)) state_d = ST_DONE;
                    else                         cnt_d   = cnt_q + 4'd1;
                end
                ST_DONE: begin
                    if (out_ready) state_d = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule
